// File: rtl/isu_crdt_sched.sv
// isu_crdt_sched: three independent one-entry issue slices; reads are gated on per-(channel, bank) return-buffer credits
module isu_crdt_sched #(
  parameter int CRDT_INIT = 4,
  parameter int CRDT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          up_ch_valid,
  output logic [2:0]          up_ch_ready,
  input  logic [1:0]          up_ch_op [3],
  input  logic [31:4]         up_ch_address [3],
  input  logic [127:0]        up_ch_data [3],
  output logic [2:0]          dn_ch_valid,
  input  logic [2:0]          dn_ch_enable,
  output logic [1:0]          dn_ch_op [3],
  output logic [31:4]         dn_ch_address [3],
  output logic [127:0]        dn_ch_data [3],
  input  logic [2:0]          crdt_rtn_bank [4],
  output logic [CRDT_W-1:0]   crdt_cnt [3][4],
  output logic                sched_idle,
  output logic                crdt_err
);
  localparam logic [CRDT_W-1:0] INIT = CRDT_W'(CRDT_INIT);
  localparam logic [CRDT_W-1:0] ONE  = CRDT_W'(1);
  logic [2:0]        full_q, full_d, up_hs, dn_hs, need;
  logic [1:0]        bank [3];
  logic [1:0]        op_q [3];
  logic [31:4]       addr_q [3];
  logic [127:0]      data_q [3];
  logic [CRDT_W-1:0] cnt_q [3][4];
  logic [CRDT_W-1:0] cnt_d [3][4];
  logic [3:0]        dec [3];
  logic [3:0]        inc [3];
  logic              err_q, err_d;
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      bank[c] = up_ch_address[c][9:8];
      need[c] = up_ch_op[c] == 2'd0;
      up_ch_ready[c] = (!need[c] || cnt_q[c][bank[c]] != '0) && (!full_q[c] || dn_ch_enable[c]);
      up_hs[c] = up_ch_valid[c] && up_ch_ready[c];
      dn_hs[c] = full_q[c] && dn_ch_enable[c];
      full_d[c] = up_hs[c] || (full_q[c] && !dn_hs[c]);
    end
  end
  always_comb begin
    err_d = err_q;
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 4; b++) begin
        dec[c][b] = up_hs[c] && need[c] && bank[c] == 2'(b);
        inc[c][b] = crdt_rtn_bank[b][c];
        cnt_d[c][b] = (dec[c][b] == inc[c][b]) ? cnt_q[c][b] :
                      dec[c][b] ? cnt_q[c][b] - ONE :
                      (cnt_q[c][b] == INIT) ? cnt_q[c][b] : cnt_q[c][b] + ONE;
        if (inc[c][b] && !dec[c][b] && cnt_q[c][b] == INIT) err_d = 1'b1;
      end
    end
  end
  always_comb begin
    sched_idle = full_q == 3'b000;
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 4; b++)
        sched_idle = sched_idle && cnt_q[c][b] == INIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      err_q  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        op_q[c]   <= '0;
        addr_q[c] <= '0;
        data_q[c] <= '0;
        for (int b = 0; b < 4; b++) cnt_q[c][b] <= INIT;
      end
    end else begin
      full_q <= full_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      for (int c = 0; c < 3; c++) begin
        if (up_hs[c]) begin
          op_q[c]   <= up_ch_op[c];
          addr_q[c] <= up_ch_address[c];
          data_q[c] <= up_ch_data[c];
        end
      end
    end
  end
  assign dn_ch_valid   = full_q;
  assign dn_ch_op      = op_q;
  assign dn_ch_address = addr_q;
  assign dn_ch_data    = data_q;
  assign crdt_cnt      = cnt_q;
  assign crdt_err      = err_q;
endmodule

// File: tb/tb_isu_crdt_sched.sv
// tb_isu_crdt_sched: directed scenario checks for the credit issue scheduler
module tb_isu_crdt_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   up_ch_valid, up_ch_ready, dn_ch_valid, dn_ch_enable;
  logic [1:0]   up_ch_op [3];
  logic [31:4]  up_ch_address [3];
  logic [127:0] up_ch_data [3];
  logic [1:0]   dn_ch_op [3];
  logic [31:4]  dn_ch_address [3];
  logic [127:0] dn_ch_data [3];
  logic [2:0]   crdt_rtn_bank [4];
  logic [2:0]   crdt_cnt [3][4];
  logic         sched_idle, crdt_err;
  int checks = 0;
  int errors = 0;
  isu_crdt_sched #(.CRDT_INIT(4), .CRDT_W(3)) dut (
    .clk(clk), .rst(rst),
    .up_ch_valid(up_ch_valid), .up_ch_ready(up_ch_ready), .up_ch_op(up_ch_op),
    .up_ch_address(up_ch_address), .up_ch_data(up_ch_data),
    .dn_ch_valid(dn_ch_valid), .dn_ch_enable(dn_ch_enable), .dn_ch_op(dn_ch_op),
    .dn_ch_address(dn_ch_address), .dn_ch_data(dn_ch_data),
    .crdt_rtn_bank(crdt_rtn_bank), .crdt_cnt(crdt_cnt),
    .sched_idle(sched_idle), .crdt_err(crdt_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:4] mk_addr(input int bank, input int tag);
    logic [31:4] a;
    a = '0;
    a[31:12] = 20'(tag);
    a[9:8] = 2'(bank);
    return a;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    up_ch_valid = '0;
    dn_ch_enable = '0;
    for (int c = 0; c < 3; c++) begin
      up_ch_op[c] = '0;
      up_ch_address[c] = '0;
      up_ch_data[c] = '0;
    end
    for (int b = 0; b < 4; b++) crdt_rtn_bank[b] = '0;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (dn_ch_valid !== 3'b000) begin errors++; $display("FAIL reset_dn_valid: got %b exp 000", dn_ch_valid); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (dn_ch_op[c] !== 2'd0 || dn_ch_address[c] !== 28'd0 || dn_ch_data[c] !== 128'd0) begin errors++; $display("FAIL reset_payload ch%0d: op %0d addr %h data %h exp all 0", c, dn_ch_op[c], dn_ch_address[c], dn_ch_data[c]); end
      for (int b = 0; b < 4; b++) begin
        checks++; if (crdt_cnt[c][b] !== 3'd4) begin errors++; $display("FAIL reset_cnt[%0d][%0d]: got %0d exp 4", c, b, crdt_cnt[c][b]); end
      end
    end
    checks++; if (crdt_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", crdt_err); end
    tick();
    checks++; if (sched_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", sched_idle); end
  endtask
  task automatic test_read_credits();
    dn_ch_enable = 3'b001;
    up_ch_valid = 3'b001;
    up_ch_op[0] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      up_ch_address[0] = mk_addr(0, i);
      #1;
      checks++; if (up_ch_ready[0] !== 1'b1) begin errors++; $display("FAIL rd_ready issue%0d: got %b exp 1", i, up_ch_ready[0]); end
      tick();
      checks++; if (dn_ch_valid[0] !== 1'b1 || dn_ch_address[0] !== mk_addr(0, i)) begin errors++; $display("FAIL rd_issue%0d: valid %b addr %h exp 1 %h", i, dn_ch_valid[0], dn_ch_address[0], mk_addr(0, i)); end
      checks++; if (crdt_cnt[0][0] !== 3'(3 - i)) begin errors++; $display("FAIL rd_cnt issue%0d: got %0d exp %0d", i, crdt_cnt[0][0], 3 - i); end
    end
    up_ch_address[0] = mk_addr(0, 4);
    #1;
    checks++; if (up_ch_ready[0] !== 1'b0) begin errors++; $display("FAIL rd_fifth_stall: got %b exp 0", up_ch_ready[0]); end
    for (int b = 1; b < 4; b++) begin
      checks++; if (crdt_cnt[0][b] !== 3'd4) begin errors++; $display("FAIL rd_other_bank cnt[0][%0d]: got %0d exp 4", b, crdt_cnt[0][b]); end
    end
  endtask
  task automatic test_hol_blocking();
    tick();
    checks++; if (up_ch_ready[0] !== 1'b0 || dn_ch_valid[0] !== 1'b0) begin errors++; $display("FAIL hol_stalled: ready %b valid %b exp 0 0", up_ch_ready[0], dn_ch_valid[0]); end
    crdt_rtn_bank[0] = 3'b001;
    #1;
    checks++; if (up_ch_ready[0] !== 1'b0) begin errors++; $display("FAIL hol_no_bypass: got %b exp 0", up_ch_ready[0]); end
    tick();
    crdt_rtn_bank[0] = 3'b000;
    #1;
    checks++; if (crdt_cnt[0][0] !== 3'd1 || up_ch_ready[0] !== 1'b1) begin errors++; $display("FAIL hol_credit_back: cnt %0d ready %b exp 1 1", crdt_cnt[0][0], up_ch_ready[0]); end
    tick();
    checks++; if (dn_ch_valid[0] !== 1'b1 || dn_ch_op[0] !== 2'd0 || dn_ch_address[0] !== mk_addr(0, 4) || crdt_cnt[0][0] !== 3'd0) begin errors++; $display("FAIL hol_read_issue: valid %b op %0d addr %h cnt %0d exp 1 0 %h 0", dn_ch_valid[0], dn_ch_op[0], dn_ch_address[0], crdt_cnt[0][0], mk_addr(0, 4)); end
    up_ch_op[0] = 2'd1;
    up_ch_address[0] = mk_addr(0, 5);
    up_ch_data[0] = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
    #1;
    checks++; if (up_ch_ready[0] !== 1'b1) begin errors++; $display("FAIL hol_write_ready: got %b exp 1", up_ch_ready[0]); end
    tick();
    checks++; if (dn_ch_valid[0] !== 1'b1 || dn_ch_op[0] !== 2'd1 || dn_ch_data[0] !== 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa || crdt_cnt[0][0] !== 3'd0) begin errors++; $display("FAIL hol_write_issue: valid %b op %0d data %h cnt %0d", dn_ch_valid[0], dn_ch_op[0], dn_ch_data[0], crdt_cnt[0][0]); end
    up_ch_valid = 3'b000;
    tick();
    checks++; if (dn_ch_valid[0] !== 1'b0) begin errors++; $display("FAIL hol_drain: got %b exp 0", dn_ch_valid[0]); end
  endtask
  task automatic test_same_cycle();
    dn_ch_enable = 3'b010;
    up_ch_valid = 3'b010;
    up_ch_op[1] = 2'd0;
    up_ch_address[1] = mk_addr(1, 7);
    tick();
    tick();
    checks++; if (crdt_cnt[1][1] !== 3'd2) begin errors++; $display("FAIL same_pre_cnt: got %0d exp 2", crdt_cnt[1][1]); end
    crdt_rtn_bank[1] = 3'b010;
    #1;
    checks++; if (up_ch_ready[1] !== 1'b1) begin errors++; $display("FAIL same_ready: got %b exp 1", up_ch_ready[1]); end
    tick();
    crdt_rtn_bank[1] = 3'b000;
    up_ch_valid = 3'b000;
    checks++; if (crdt_cnt[1][1] !== 3'd2 || crdt_err !== 1'b0) begin errors++; $display("FAIL same_cnt: cnt %0d err %b exp 2 0", crdt_cnt[1][1], crdt_err); end
    tick();
  endtask
  task automatic test_err_sticky();
    dn_ch_enable = 3'b000;
    checks++; if (crdt_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b exp 0", crdt_err); end
    crdt_rtn_bank[3] = 3'b100;
    tick();
    crdt_rtn_bank[3] = 3'b000;
    checks++; if (crdt_cnt[2][3] !== 3'd4 || crdt_err !== 1'b1) begin errors++; $display("FAIL err_set: cnt %0d err %b exp 4 1", crdt_cnt[2][3], crdt_err); end
    tick();
    tick();
    tick();
    checks++; if (crdt_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", crdt_err); end
  endtask
  task automatic test_stall_all();
    dn_ch_enable = 3'b000;
    up_ch_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      up_ch_op[c] = 2'd0;
      up_ch_address[c] = mk_addr(2, 16 + c);
      up_ch_data[c] = 128'(c + 32'h100);
    end
    #1;
    checks++; if (up_ch_ready !== 3'b111) begin errors++; $display("FAIL stall_first_ready: got %b exp 111", up_ch_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      up_ch_address[c] = mk_addr(2, 32 + c);
      up_ch_data[c] = 128'(c + 32'h200);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (up_ch_ready !== 3'b000 || dn_ch_valid !== 3'b111) begin errors++; $display("FAIL stall_hold%0d: ready %b valid %b exp 000 111", k, up_ch_ready, dn_ch_valid); end
      for (int c = 0; c < 3; c++) begin
        checks++; if (dn_ch_address[c] !== mk_addr(2, 16 + c) || dn_ch_data[c] !== 128'(c + 32'h100) || crdt_cnt[c][2] !== 3'd3) begin errors++; $display("FAIL stall_payload%0d ch%0d: addr %h data %h cnt %0d", k, c, dn_ch_address[c], dn_ch_data[c], crdt_cnt[c][2]); end
      end
      tick();
    end
    up_ch_valid = 3'b000;
    dn_ch_enable = 3'b111;
    tick();
    dn_ch_enable = 3'b000;
    checks++; if (dn_ch_valid !== 3'b000) begin errors++; $display("FAIL stall_release: got %b exp 000", dn_ch_valid); end
  endtask
  task automatic test_rst_mid();
    crdt_rtn_bank[0] = 3'b001;
    up_ch_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      up_ch_op[c] = 2'd1;
      up_ch_address[c] = mk_addr(0, 48 + c);
    end
    tick();
    crdt_rtn_bank[0] = 3'b000;
    checks++; if (crdt_cnt[0][0] !== 3'd1 || dn_ch_valid !== 3'b111 || sched_idle !== 1'b0) begin errors++; $display("FAIL rstmid_pre: cnt %0d valid %b idle %b exp 1 111 0", crdt_cnt[0][0], dn_ch_valid, sched_idle); end
    rst = 1'b1;
    dn_ch_enable = 3'b111;
    tick();
    rst = 1'b0;
    up_ch_valid = 3'b000;
    dn_ch_enable = 3'b000;
    checks++; if (dn_ch_valid !== 3'b000 || crdt_err !== 1'b0) begin errors++; $display("FAIL rstmid_clear: valid %b err %b exp 000 0", dn_ch_valid, crdt_err); end
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 4; b++) begin
        checks++; if (crdt_cnt[c][b] !== 3'd4) begin errors++; $display("FAIL rstmid_cnt[%0d][%0d]: got %0d exp 4", c, b, crdt_cnt[c][b]); end
      end
    tick();
    checks++; if (sched_idle !== 1'b1 || dn_ch_valid !== 3'b000) begin errors++; $display("FAIL rstmid_idle: idle %b valid %b exp 1 000", sched_idle, dn_ch_valid); end
  endtask
  initial begin
    test_reset();
    test_read_credits();
    test_hol_blocking();
    test_same_cycle();
    test_err_sticky();
    test_stall_all();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
